// File: rtl/px_seq_pkg.sv
// Shared types and helpers for the pixel-array sequencer.
package px_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READ,
    GAP
  } state_t;

  localparam int unsigned MIN_DUR = 1;

  // Forces a programmed value into [MIN_DUR, hi].
  function automatic int unsigned clamp_cfg(input int unsigned v, input int unsigned hi);
    if (v < MIN_DUR) return MIN_DUR;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/px_seq_ctrl_if.sv
// System-controller / sequencer bundle: configuration and commands in, analog control lines out.
interface px_seq_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int ROW_W  = 4,
  parameter int FCNT_W = 16
);
  logic              start;
  logic              continuous;
  logic              abort;
  logic [CNT_W-1:0]  t_erase;
  logic [CNT_W-1:0]  t_expose;
  logic [CNT_W-1:0]  t_convert;
  logic [CNT_W-1:0]  t_read;
  logic [ROW_W:0]    n_rows;
  logic              erase;
  logic              expose;
  logic              convert;
  logic              read;
  logic [ROW_W-1:0]  row_sel;
  logic              busy;
  logic              frame_done;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output start, continuous, abort, t_erase, t_expose, t_convert, t_read, n_rows,
    input  erase, expose, convert, read, row_sel, busy, frame_done, frame_cnt
  );

  modport slave (
    input  start, continuous, abort, t_erase, t_expose, t_convert, t_read, n_rows,
    output erase, expose, convert, read, row_sel, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/px_phase_timer.sv
// Down-counter shared by every phase and row; tc marks the last cycle of the loaded duration.
module px_phase_timer
  import px_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [CNT_W:0] dur,
  output logic           tc
);

  logic [CNT_W:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= dur;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == (CNT_W+1)'(MIN_DUR));

endmodule

// File: rtl/px_seq_ctrl.sv
// Erase -> expose -> convert -> per-row read-out sequencer with one-cycle gaps between phases.
module px_seq_ctrl
  import px_seq_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int ROW_W  = 4,
  parameter int FCNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  px_seq_ctrl_if.slave  bus
);

  localparam int unsigned DUR_MAX = (1 << CNT_W) - 1;
  localparam int unsigned ROW_MAX = 1 << ROW_W;

  state_t           state;
  state_t           ret;
  logic [CNT_W-1:0] tx_l, tc_l, tr_l;
  logic [ROW_W:0]   n_l;
  logic [CNT_W-1:0] te_in, tx_in, tc_in, tr_in;
  logic [ROW_W:0]   n_in;
  logic             row_last, final_gap, restart;
  logic             tmr_load, tmr_tc;
  logic [CNT_W:0]   tmr_val;

  assign te_in = CNT_W'(clamp_cfg(32'(bus.t_erase), DUR_MAX));
  assign tx_in = CNT_W'(clamp_cfg(32'(bus.t_expose), DUR_MAX));
  assign tc_in = CNT_W'(clamp_cfg(32'(bus.t_convert), DUR_MAX));
  assign tr_in = CNT_W'(clamp_cfg(32'(bus.t_read), DUR_MAX));
  assign n_in  = (ROW_W+1)'(clamp_cfg(32'(bus.n_rows), ROW_MAX));

  assign row_last  = ({1'b0, bus.row_sel} == (n_l - 1'b1));
  assign final_gap = (state == GAP) && (ret == READ) && row_last;
  assign restart   = !bus.abort &&
                     (((state == IDLE) && bus.start) || (final_gap && bus.continuous));

  // Timer is loaded on every edge that enters a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (restart) begin
      tmr_load = 1'b1;
      tmr_val  = {1'b0, te_in};
    end else if ((state == GAP) && !bus.abort && !final_gap) begin
      tmr_load = 1'b1;
      case (ret)
        ERASE:   tmr_val = {1'b0, tx_l};
        EXPOSE:  tmr_val = {1'b0, tc_l};
        default: tmr_val = {1'b0, tr_l};
      endcase
    end
  end

  px_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dur  (tmr_val),
    .tc   (tmr_tc)
  );

  // Configuration holding registers carry no reset.
  always_ff @(posedge clk) begin
    if (restart) begin
      tx_l <= tx_in;
      tc_l <= tc_in;
      tr_l <= tr_in;
      n_l  <= n_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ret            <= IDLE;
      bus.erase      <= 1'b0;
      bus.expose     <= 1'b0;
      bus.convert    <= 1'b0;
      bus.read       <= 1'b0;
      bus.row_sel    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_cnt  <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      if ((state != IDLE) && bus.abort) begin
        state       <= IDLE;
        bus.erase   <= 1'b0;
        bus.expose  <= 1'b0;
        bus.convert <= 1'b0;
        bus.read    <= 1'b0;
        bus.row_sel <= '0;
        bus.busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (restart) begin
              state     <= ERASE;
              bus.erase <= 1'b1;
              bus.busy  <= 1'b1;
            end
          end
          ERASE: if (tmr_tc) begin
            state     <= GAP;
            ret       <= ERASE;
            bus.erase <= 1'b0;
          end
          EXPOSE: if (tmr_tc) begin
            state      <= GAP;
            ret        <= EXPOSE;
            bus.expose <= 1'b0;
          end
          CONVERT: if (tmr_tc) begin
            state       <= GAP;
            ret         <= CONVERT;
            bus.convert <= 1'b0;
          end
          READ: if (tmr_tc) begin
            state    <= GAP;
            ret      <= READ;
            bus.read <= 1'b0;
            if (row_last) begin
              bus.frame_done <= 1'b1;
              bus.frame_cnt  <= bus.frame_cnt + 1'b1;
            end
          end
          GAP: begin
            case (ret)
              ERASE: begin
                state      <= EXPOSE;
                bus.expose <= 1'b1;
              end
              EXPOSE: begin
                state       <= CONVERT;
                bus.convert <= 1'b1;
              end
              CONVERT: begin
                state       <= READ;
                bus.read    <= 1'b1;
                bus.row_sel <= '0;
              end
              default: begin
                if (!row_last) begin
                  state       <= READ;
                  bus.read    <= 1'b1;
                  bus.row_sel <= bus.row_sel + 1'b1;
                end else if (restart) begin
                  state       <= ERASE;
                  bus.erase   <= 1'b1;
                  bus.row_sel <= '0;
                end else begin
                  state       <= IDLE;
                  bus.busy    <= 1'b0;
                  bus.row_sel <= '0;
                end
              end
            endcase
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
